// File: rtl/lsu_unit.sv
// Load/store unit: word-addressed req/gnt/rvalid bus master with lane alignment,
// load extension and range/alignment fault reporting. Optional macro: MISALIGNED_SPLIT_EN.
package lsu_pkg;
   localparam logic [31:0] RAM_LOWER  = 32'h2000_0000;
   localparam logic [31:0] RAM_HIGHER = 32'h2000_3FFF;

   typedef enum logic [2:0] {
      MEM_LB  = 3'b000,
      MEM_LH  = 3'b001,
      MEM_LW  = 3'b010,
      MEM_LBU = 3'b011,
      MEM_LHU = 3'b100,
      MEM_SB  = 3'b101,
      MEM_SH  = 3'b110,
      MEM_SW  = 3'b111
   } mem_op_t;
endpackage

// state | meaning
// IDLE  | waiting for req_i, access checked here
// REQ0  | first (or only) beat requested, waiting for gnt
// WAIT0 | first beat granted, waiting for rvalid
// REQ1  | second beat of a split access requested
// WAIT1 | second beat granted, waiting for rvalid
// DONE  | access retired, result/fault presented for one cycle
module lsu_unit
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic [2:0]  mem_op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;
   state_t state_q, state_d;

   mem_op_t     op;
   logic [1:0]  off;
   logic        is_byte, is_half, is_word, is_store, is_signed;
   logic        misal, split, range_err;
   logic [1:0]  cause_d;
   logic [31:0] word_a, word_b;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide, rdata_wide;
   logic [31:0] raw, load_data;
   logic [31:0] beat0_q, rdata_q;
   logic        fault_q;
   logic [1:0]  cause_q;

   assign op       = mem_op_t'(mem_op_i);
   assign off      = addr_i[1:0];
   assign is_store = (mem_op_i >= 3'b101);

   always_comb begin
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      is_signed = 1'b0;
      case (op)
         MEM_LB:           begin is_byte = 1'b1; is_signed = 1'b1; end
         MEM_LH:           begin is_half = 1'b1; is_signed = 1'b1; end
         MEM_LBU, MEM_SB:  is_byte = 1'b1;
         MEM_LHU, MEM_SH:  is_half = 1'b1;
         default:          is_word = 1'b1;
      endcase
   end

   assign misal     = (is_half && off == 2'd3) || (is_word && off != 2'd0);
   assign split     = SplitEn && misal;
   assign word_a    = {2'b00, addr_i[31:2]};
   assign word_b    = word_a + 32'd1;
   assign range_err = (word_a < RAM_LOWER) || (word_a > RAM_HIGHER) ||
                      (split && ((word_b < RAM_LOWER) || (word_b > RAM_HIGHER)));
   assign cause_d   = (misal && !SplitEn) ? 2'b01 : (range_err ? 2'b10 : 2'b00);

   // Low half of the wide vectors is beat 0, high half is beat 1 of a split access.
   assign be_wide    = {4'b0000, is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001)} << off;
   assign wdata_wide = {32'd0, wdata_i} << {off, 3'b000};
   assign rdata_wide = (state_q == WAIT1) ? {data_rdata_i, beat0_q} : {32'd0, data_rdata_i};
   assign raw        = rdata_wide[{1'b0, off, 3'b000} +: 32];

   always_comb begin
      load_data = raw;
      if (is_byte)
         load_data = {{24{is_signed & raw[7]}}, raw[7:0]};
      else if (is_half)
         load_data = {{16{is_signed & raw[15]}}, raw[15:0]};
   end

   always_comb begin
      state_d      = state_q;
      data_req_o   = 1'b0;
      data_be_o    = 4'b0000;
      data_addr_o  = 32'd0;
      data_wdata_o = 32'd0;
      case (state_q)
         IDLE:  if (req_i) state_d = (cause_d != 2'b00) ? DONE : REQ0;
         REQ0: begin
            data_req_o   = 1'b1;
            data_be_o    = be_wide[3:0];
            data_addr_o  = {addr_i[31:2], 2'b00};
            data_wdata_o = wdata_wide[31:0];
            if (data_gnt_i) state_d = WAIT0;
         end
         WAIT0: if (data_rvalid_i) state_d = split ? REQ1 : DONE;
         REQ1: begin
            data_req_o   = 1'b1;
            data_be_o    = be_wide[7:4];
            data_addr_o  = {addr_i[31:2] + 30'd1, 2'b00};
            data_wdata_o = wdata_wide[63:32];
            if (data_gnt_i) state_d = WAIT1;
         end
         WAIT1: if (data_rvalid_i) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign data_we_o = data_req_o && is_store;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         beat0_q <= 32'd0;
         rdata_q <= 32'd0;
         fault_q <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_q == WAIT0 && data_rvalid_i)
            beat0_q <= data_rdata_i;
         // Result registers are non-zero only during the single DONE cycle.
         if (state_d == DONE) begin
            fault_q <= (state_q == IDLE);
            cause_q <= (state_q == IDLE) ? cause_d : 2'b00;
            rdata_q <= (state_q == IDLE || is_store) ? 32'd0 : load_data;
         end else begin
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            rdata_q <= 32'd0;
         end
      end
   end

   assign stall_o       = req_i && (state_q != DONE);
   assign done_o        = (state_q == DONE);
   assign rdata_o       = rdata_q;
   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit with a small bus responder
// (combinational gnt, rvalid one cycle after gnt unless held).
module tb_lsu_unit;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic [2:0]  mem_op_i = 3'b000;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] wdata_i = 32'd0;
   logic        stall_o, done_o, fault_o;
   logic [31:0] rdata_o;
   logic [1:0]  fault_cause_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;

   logic        gnt_en = 1'b0;
   logic        rv_hold = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'd0;
   logic [31:0] rd_even = 32'd0;
   logic [31:0] rd_odd = 32'd0;

   int          vectors = 0;
   int          miscompares = 0;
   int          nb, nreq, ncyc;
   logic [31:0] b_addr [2];
   logic [31:0] b_wd [2];
   logic [3:0]  b_be [2];
   logic        b_we [2];
   logic [31:0] r_data;
   logic        r_flt, r_stall_done;
   logic [1:0]  r_cause;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                          LHU = 3'b100, SH = 3'b110;

   lsu_unit dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .mem_op_i(mem_op_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
      .rdata_o(rdata_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   assign data_gnt_i    = data_req_o & gnt_en;
   assign data_rvalid_i = pend & ~rv_hold;
   assign data_rdata_i  = data_rvalid_i ? (pend_addr[2] ? rd_odd : rd_even) : 32'h0;

   always @(posedge clk_i) begin
      if (data_req_o && data_gnt_i) begin
         pend      <= 1'b1;
         pend_addr <= data_addr_o;
      end else if (data_rvalid_i) begin
         pend <= 1'b0;
      end
   end

   // Runs one access starting at posedge+1 (cycle 0); records beats and the DONE-cycle outputs.
   task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int gnt_wait);
      nb = 0; nreq = 0; ncyc = -1;
      r_data = 32'hx; r_flt = 1'bx; r_cause = 2'bx; r_stall_done = 1'bx;
      mem_op_i = op; addr_i = addr; wdata_i = wd; req_i = 1'b1;
      gnt_en = (gnt_wait == 0);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (data_req_o) nreq++;
         if (data_req_o && data_gnt_i && nb < 2) begin
            b_addr[nb] = data_addr_o; b_be[nb] = data_be_o;
            b_wd[nb] = data_wdata_o;  b_we[nb] = data_we_o;
            nb++;
         end
         if (done_o) begin
            ncyc = c; r_data = rdata_o; r_flt = fault_o;
            r_cause = fault_cause_o; r_stall_done = stall_o;
            req_i = 1'b0;
            break;
         end
         @(posedge clk_i); #1;
         gnt_en = (c + 1 >= gnt_wait);
      end
      req_i = 1'b0; gnt_en = 1'b0;
      vectors++;
      if (ncyc < 0) begin
         miscompares++;
         $display("FAIL timeout op=%0d addr=%h: done_o never seen in 40 cycles", op, addr);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({data_req_o, data_we_o, done_o, fault_o, fault_cause_o, data_be_o} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl got req=%b we=%b done=%b flt=%b cause=%b be=%b exp all 0",
                  data_req_o, data_we_o, done_o, fault_o, fault_cause_o, data_be_o);
      end
      vectors++;
      if ({data_addr_o, data_wdata_o, rdata_o} !== 96'd0) begin
         miscompares++;
         $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0", data_addr_o, data_wdata_o, rdata_o);
      end
   endtask

   task automatic test_lw_aligned();
      rd_even = 32'hDEAD_BEEF; rd_odd = 32'hDEAD_BEEF;
      do_access(LW, 32'h8000_0010, 32'd0, 0);
      vectors++;
      if (b_addr[0] !== 32'h8000_0010 || b_be[0] !== 4'b1111 || b_we[0] !== 1'b0 || nb !== 1) begin
         miscompares++;
         $display("FAIL lw_beat got addr=%h be=%b we=%b beats=%0d exp 80000010 1111 0 1",
                  b_addr[0], b_be[0], b_we[0], nb);
      end
      vectors++;
      if (ncyc !== 3) begin miscompares++; $display("FAIL lw_latency got %0d exp 3", ncyc); end
      vectors++;
      if (r_data !== 32'hDEAD_BEEF || r_flt !== 1'b0 || r_stall_done !== 1'b0) begin
         miscompares++;
         $display("FAIL lw_result got rdata=%h flt=%b stall=%b exp deadbeef 0 0", r_data, r_flt, r_stall_done);
      end
   endtask

   task automatic test_byte_loads();
      rd_even = 32'h8000_0000; rd_odd = 32'h8000_0000;
      do_access(LB, 32'h8000_0013, 32'd0, 0);
      vectors++;
      if (b_be[0] !== 4'b1000 || r_data !== 32'hFFFF_FF80) begin
         miscompares++;
         $display("FAIL lb got be=%b rdata=%h exp 1000 ffffff80", b_be[0], r_data);
      end
      do_access(LBU, 32'h8000_0013, 32'd0, 0);
      vectors++;
      if (b_be[0] !== 4'b1000 || r_data !== 32'h0000_0080) begin
         miscompares++;
         $display("FAIL lbu got be=%b rdata=%h exp 1000 00000080", b_be[0], r_data);
      end
   endtask

   task automatic test_half_loads();
      rd_even = 32'h00F0_E000; rd_odd = 32'h00F0_E000;
      do_access(LH, 32'h8000_0001, 32'd0, 0);
      vectors++;
      if (b_be[0] !== 4'b0110 || r_data !== 32'hFFFF_F0E0 || r_flt !== 1'b0) begin
         miscompares++;
         $display("FAIL lh_off1 got be=%b rdata=%h flt=%b exp 0110 fffff0e0 0", b_be[0], r_data, r_flt);
      end
      do_access(LHU, 32'h8000_0001, 32'd0, 0);
      vectors++;
      if (r_data !== 32'h0000_F0E0) begin
         miscompares++;
         $display("FAIL lhu_off1 got rdata=%h exp 0000f0e0", r_data);
      end
   endtask

   task automatic test_store_half();
      do_access(SH, 32'h8000_0006, 32'h0000_1234, 0);
      vectors++;
      if (b_we[0] !== 1'b1 || b_be[0] !== 4'b1100 || b_wd[0] !== 32'h1234_0000 ||
          b_addr[0] !== 32'h8000_0004) begin
         miscompares++;
         $display("FAIL sh_beat got we=%b be=%b wdata=%h addr=%h exp 1 1100 12340000 80000004",
                  b_we[0], b_be[0], b_wd[0], b_addr[0]);
      end
      vectors++;
      if (ncyc !== 3 || r_flt !== 1'b0) begin
         miscompares++;
         $display("FAIL sh_done got cycle=%0d flt=%b exp 3 0", ncyc, r_flt);
      end
   endtask

   task automatic test_misaligned();
      rd_even = 32'hAABB_CCDD; rd_odd = 32'h1122_3344;
      do_access(LW, 32'h8000_0002, 32'd0, 0);
`ifdef MISALIGNED_SPLIT_EN
      vectors++;
      if (nb !== 2 || b_addr[0] !== 32'h8000_0000 || b_be[0] !== 4'b1100 ||
          b_addr[1] !== 32'h8000_0004 || b_be[1] !== 4'b0011) begin
         miscompares++;
         $display("FAIL split_beats got n=%0d %h/%b %h/%b exp 2 80000000/1100 80000004/0011",
                  nb, b_addr[0], b_be[0], b_addr[1], b_be[1]);
      end
      vectors++;
      if (r_data !== 32'h3344_AABB || r_flt !== 1'b0 || ncyc !== 5) begin
         miscompares++;
         $display("FAIL split_result got rdata=%h flt=%b cycle=%0d exp 3344aabb 0 5", r_data, r_flt, ncyc);
      end
`else
      vectors++;
      if (r_flt !== 1'b1 || r_cause !== 2'b01 || nreq !== 0 || ncyc !== 1 || r_data !== 32'd0) begin
         miscompares++;
         $display("FAIL misal_fault got flt=%b cause=%b reqs=%0d cycle=%0d rdata=%h exp 1 01 0 1 0",
                  r_flt, r_cause, nreq, ncyc, r_data);
      end
`endif
   endtask

   task automatic test_range();
      do_access(LW, 32'h9000_0000, 32'd0, 0);
      vectors++;
      if (r_flt !== 1'b1 || r_cause !== 2'b10 || nreq !== 0 || ncyc !== 1) begin
         miscompares++;
         $display("FAIL range_high got flt=%b cause=%b reqs=%0d cycle=%0d exp 1 10 0 1", r_flt, r_cause, nreq, ncyc);
      end
      do_access(LW, 32'h7FFF_FFFC, 32'd0, 0);
      vectors++;
      if (r_flt !== 1'b1 || r_cause !== 2'b10 || nreq !== 0) begin
         miscompares++;
         $display("FAIL range_low got flt=%b cause=%b reqs=%0d exp 1 10 0", r_flt, r_cause, nreq);
      end
      rd_even = 32'h0123_4567; rd_odd = 32'h0123_4567;
      do_access(LW, 32'h8000_FFFC, 32'd0, 0);
      vectors++;
      if (r_flt !== 1'b0 || r_data !== 32'h0123_4567 || nreq !== 1) begin
         miscompares++;
         $display("FAIL range_top_word got flt=%b rdata=%h reqs=%0d exp 0 01234567 1", r_flt, r_data, nreq);
      end
      do_access(LH, 32'h8000_FFFF, 32'd0, 0);
      vectors++;
`ifdef MISALIGNED_SPLIT_EN
      if (r_flt !== 1'b1 || r_cause !== 2'b10 || nreq !== 0) begin
         miscompares++;
         $display("FAIL split_cross_top got flt=%b cause=%b reqs=%0d exp 1 10 0", r_flt, r_cause, nreq);
      end
`else
      if (r_flt !== 1'b1 || r_cause !== 2'b01 || nreq !== 0) begin
         miscompares++;
         $display("FAIL misal_top got flt=%b cause=%b reqs=%0d exp 1 01 0", r_flt, r_cause, nreq);
      end
`endif
   endtask

   task automatic test_gnt_wait();
      rd_even = 32'hCAFE_0001; rd_odd = 32'hCAFE_0001;
      do_access(LW, 32'h8000_0040, 32'd0, 3);
      vectors++;
      if (ncyc !== 5 || r_data !== 32'hCAFE_0001 || nreq !== 3) begin
         miscompares++;
         $display("FAIL gnt_wait got cycle=%0d rdata=%h reqs=%0d exp 5 cafe0001 3", ncyc, r_data, nreq);
      end
   endtask

   task automatic test_reset_mid_access();
      int bad;
      rd_even = 32'h5555_AAAA; rd_odd = 32'h5555_AAAA;
      rv_hold = 1'b1;
      mem_op_i = LW; addr_i = 32'h8000_0020; req_i = 1'b1; gnt_en = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      gnt_en = 1'b0;
      vectors++;
      if (data_req_o !== 1'b0 || pend !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_setup got req=%b granted=%b exp 0 1", data_req_o, pend);
      end
      rst_ni = 1'b0;
      #1;
      vectors++;
      if ({data_req_o, done_o, fault_o, data_be_o} !== 7'd0 || data_addr_o !== 32'd0 || rdata_o !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_mid got req=%b done=%b flt=%b be=%b addr=%h rdata=%h exp all 0",
                  data_req_o, done_o, fault_o, data_be_o, data_addr_o, rdata_o);
      end
      req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1; rv_hold = 1'b0;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (done_o || data_req_o || fault_o) bad++;
         @(posedge clk_i); #1;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL rst_stale_rvalid got %0d active cycles exp 0", bad);
      end
      rd_even = 32'h0BAD_F00D; rd_odd = 32'h0BAD_F00D;
      do_access(LW, 32'h8000_0020, 32'd0, 0);
      vectors++;
      if (ncyc !== 3 || r_data !== 32'h0BAD_F00D || r_flt !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_recover got cycle=%0d rdata=%h flt=%b exp 3 0badf00d 0", ncyc, r_data, r_flt);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      test_reset();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      test_lw_aligned();
      test_byte_loads();
      test_half_loads();
      test_store_half();
      test_misaligned();
      test_range();
      test_gnt_wait();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
